// File: rtl/lvdc_timing_pkg.sv
// Shared timing definitions for the LVDC bit-time phase generator:
// sequencer states, strobe slot assignments and default counts.
package lvdc_timing_pkg;

    typedef enum logic [1:0] {
        ST_HALT     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2,
        ST_STOPPING = 2'd3
    } phase_state_e;

    localparam int SLOT_W = 4;
    localparam int BCNT_W = 4;
    localparam int WCNT_W = 2;

    localparam logic [SLOT_W-1:0] SLOT_V1 = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_W2 = 4'd2;
    localparam logic [SLOT_W-1:0] SLOT_X7 = 4'd4;
    localparam logic [SLOT_W-1:0] SLOT_Y1 = 4'd5;
    localparam logic [SLOT_W-1:0] SLOT_Z6 = 4'd6;

    localparam int DEF_CYC_PER_BIT      = 8;
    localparam int DEF_BITS_PER_WORD    = 14;
    localparam int DEF_WORDS_PER_SECTOR = 4;

endpackage

// File: rtl/lvdc_bit_counter.sv
// Slot -> bit time -> word time counter cascade. Exposes next-state values
// so the parent can register strobes that line up with the counter registers.
module lvdc_bit_counter
    import lvdc_timing_pkg::*;
#(
    parameter int CYC_PER_BIT      = DEF_CYC_PER_BIT,
    parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int WORDS_PER_SECTOR = DEF_WORDS_PER_SECTOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    output logic [SLOT_W-1:0] slot_d_o,
    output logic [BCNT_W-1:0] bcnt_d_o,
    output logic [BCNT_W-1:0] bcnt_o,
    output logic [WCNT_W-1:0] wcnt_o
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CYC_PER_BIT - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BITS_PER_WORD - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_SECTOR - 1);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        slot_d = slot_q;
        bcnt_d = bcnt_q;
        wcnt_d = wcnt_q;
        if (en_i) begin
            if (slot_q == SLOT_LAST) begin
                slot_d = '0;
                if (bcnt_q == BCNT_LAST) begin
                    bcnt_d = '0;
                    wcnt_d = (wcnt_q == WCNT_LAST) ? '0 : wcnt_q + 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            bcnt_q <= '0;
            wcnt_q <= '0;
        end else begin
            slot_q <= slot_d;
            bcnt_q <= bcnt_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign slot_d_o = slot_d;
    assign bcnt_d_o = bcnt_d;
    assign bcnt_o   = bcnt_q;
    assign wcnt_o   = wcnt_q;

endmodule

// File: rtl/lvdc_phase_timer.sv
// Bit-time phase strobe generator with run/halt/single-step sequencing.
// Strobes start and stop only on word boundaries.
module lvdc_phase_timer
    import lvdc_timing_pkg::*;
#(
    parameter int CYC_PER_BIT      = DEF_CYC_PER_BIT,
    parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int WORDS_PER_SECTOR = DEF_WORDS_PER_SECTOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RUN,
    input  logic              STEP,
    output logic              V1,
    output logic              W2,
    output logic              X7,
    output logic              Y1,
    output logic              Z6,
    output logic              V4MOD4,
    output logic              RUNV,
    output logic [BCNT_W-1:0] BCNT,
    output logic [WCNT_W-1:0] WCNT,
    output logic              WEND
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CYC_PER_BIT - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BITS_PER_WORD - 1);

    phase_state_e      state_q, state_d;
    logic              runv_q, runv_d;
    logic              v1_q, w2_q, x7_q, y1_q, z6_q, v4mod4_q, wend_q;
    logic [SLOT_W-1:0] slot_d;
    logic [BCNT_W-1:0] bcnt_d;

    lvdc_bit_counter #(
        .CYC_PER_BIT      (CYC_PER_BIT),
        .BITS_PER_WORD    (BITS_PER_WORD),
        .WORDS_PER_SECTOR (WORDS_PER_SECTOR)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .en_i     (runv_q),
        .slot_d_o (slot_d),
        .bcnt_d_o (bcnt_d),
        .bcnt_o   (BCNT),
        .wcnt_o   (WCNT)
    );

    // wend_q marks the final cycle of a word, so any exit to HALT here
    // coincides with the counters wrapping back to slot 0, bit 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (RUN)       state_d = ST_RUNNING;
                else if (STEP) state_d = ST_STEPPING;
            end
            ST_RUNNING: begin
                if (!RUN) state_d = wend_q ? ST_HALT : ST_STOPPING;
            end
            ST_STEPPING: begin
                if (wend_q) state_d = ST_HALT;
            end
            ST_STOPPING: begin
                if (RUN)         state_d = ST_RUNNING;
                else if (wend_q) state_d = ST_HALT;
            end
            default: state_d = ST_HALT;
        endcase
        runv_d = (state_d != ST_HALT);
    end

    // Strobes decode the counters' next values so each registered strobe
    // is high in the same cycle the counter register holds its slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HALT;
            runv_q   <= 1'b0;
            v1_q     <= 1'b0;
            w2_q     <= 1'b0;
            x7_q     <= 1'b0;
            y1_q     <= 1'b0;
            z6_q     <= 1'b0;
            v4mod4_q <= 1'b0;
            wend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            runv_q   <= runv_d;
            v1_q     <= runv_d && (slot_d == SLOT_V1);
            w2_q     <= runv_d && (slot_d == SLOT_W2);
            x7_q     <= runv_d && (slot_d == SLOT_X7);
            y1_q     <= runv_d && (slot_d == SLOT_Y1);
            z6_q     <= runv_d && (slot_d == SLOT_Z6);
            v4mod4_q <= runv_d && (slot_d == SLOT_V1) && (bcnt_d[1:0] == 2'b00);
            wend_q   <= runv_d && (slot_d == SLOT_LAST) && (bcnt_d == BCNT_LAST);
        end
    end

    assign V1     = v1_q;
    assign W2     = w2_q;
    assign X7     = x7_q;
    assign Y1     = y1_q;
    assign Z6     = z6_q;
    assign V4MOD4 = v4mod4_q;
    assign RUNV   = runv_q;
    assign WEND   = wend_q;

endmodule

// File: tb/tb_lvdc_phase_timer.sv
// Directed self-checking bench for lvdc_phase_timer at default counts
// (8 slots per bit, 14 bits per word, 4 words per sector).
module tb_lvdc_phase_timer;

    logic       clk = 1'b0;
    logic       rst, RUN, STEP;
    logic       V1, W2, X7, Y1, Z6, V4MOD4, RUNV, WEND;
    logic [3:0] BCNT;
    logic [1:0] WCNT;

    int n_checks = 0;
    int n_fail   = 0;

    lvdc_phase_timer dut (
        .clk    (clk),
        .rst    (rst),
        .RUN    (RUN),
        .STEP   (STEP),
        .V1     (V1),
        .W2     (W2),
        .X7     (X7),
        .Y1     (Y1),
        .Z6     (Z6),
        .V4MOD4 (V4MOD4),
        .RUNV   (RUNV),
        .BCNT   (BCNT),
        .WCNT   (WCNT),
        .WEND   (WEND)
    );

    always #5 clk = ~clk;

    wire [11:0] obs = {V1, W2, X7, Y1, Z6, V4MOD4, WEND, RUNV, BCNT};

    // Expected {V1,W2,X7,Y1,Z6,V4MOD4,WEND,RUNV,BCNT} for the c-th cycle
    // (1-based) of a continuous strobe stream starting at slot 0, bit 0.
    function automatic logic [11:0] exp_run(int c);
        int s, b;
        s = (c - 1) % 8;
        b = ((c - 1) / 8) % 14;
        return {s == 0, s == 2, s == 4, s == 5, s == 6,
                (s == 0) && (b % 4 == 0), (s == 7) && (b == 13), 1'b1, 4'(b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; RUN = 1'b0; STEP = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; RUN = 1'b1; STEP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({obs, WCNT} !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %h want 0000", i, {obs, WCNT});
            end
        end
        rst = 1'b0; RUN = 1'b0; STEP = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({obs, WCNT} !== 14'h0) begin
                n_fail++;
                $display("FAIL halt_idle cyc %0d: got %h want 0000", i, {obs, WCNT});
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_run_word();
        int v4 = 0;
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 112; c++) begin
            tick();
            if (V4MOD4) v4++;
            n_checks++;
            if ({obs, WCNT} !== {exp_run(c), 2'd0}) begin
                n_fail++;
                $display("FAIL run_word c=%0d: got %h want %h", c, {obs, WCNT}, {exp_run(c), 2'd0});
            end
        end
        tick();
        n_checks++;
        if ({obs, WCNT} !== {exp_run(113), 2'd1}) begin
            n_fail++;
            $display("FAIL run_word_wrap: got %h want %h", {obs, WCNT}, {exp_run(113), 2'd1});
        end
        n_checks++;
        if (v4 !== 4) begin
            n_fail++;
            $display("FAIL run_word_v4mod4_count: got %0d want 4", v4);
        end
        RUN = 1'b0;
        $display("test_run_word: done");
    endtask

    task automatic test_step();
        int v1n = 0, z6n = 0, v4n = 0;
        do_reset();
        STEP = 1'b1;
        for (int c = 1; c <= 112; c++) begin
            tick();
            if (c == 1)  STEP = 1'b0;
            if (c == 50) STEP = 1'b1;
            if (c == 51) STEP = 1'b0;
            if (V1) v1n++;
            if (Z6) z6n++;
            if (V4MOD4) v4n++;
            n_checks++;
            if ({obs, WCNT} !== {exp_run(c), 2'd0}) begin
                n_fail++;
                $display("FAIL step c=%0d: got %h want %h", c, {obs, WCNT}, {exp_run(c), 2'd0});
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({obs, WCNT} !== {12'h0, 2'd1}) begin
                n_fail++;
                $display("FAIL step_halted cyc %0d: got %h want %h", i, {obs, WCNT}, {12'h0, 2'd1});
            end
        end
        n_checks++;
        if (v1n !== 14 || z6n !== 14 || v4n !== 4) begin
            n_fail++;
            $display("FAIL step_counts: got v1=%0d z6=%0d v4=%0d want 14 14 4", v1n, z6n, v4n);
        end
        $display("test_step: done");
    endtask

    task automatic test_stop();
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 112; c++) begin
            tick();
            if (c == 41) RUN = 1'b0;
            n_checks++;
            if ({obs, WCNT} !== {exp_run(c), 2'd0}) begin
                n_fail++;
                $display("FAIL stop c=%0d: got %h want %h", c, {obs, WCNT}, {exp_run(c), 2'd0});
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({obs, WCNT} !== {12'h0, 2'd1}) begin
                n_fail++;
                $display("FAIL stop_halted cyc %0d: got %h want %h", i, {obs, WCNT}, {12'h0, 2'd1});
            end
        end
        $display("test_stop: done");
    endtask

    task automatic test_stop_resume();
        logic [1:0] wexp;
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            tick();
            if (c == 41) RUN = 1'b0;
            if (c == 73) RUN = 1'b1;
            wexp = (c > 112) ? 2'd1 : 2'd0;
            n_checks++;
            if ({obs, WCNT} !== {exp_run(c), wexp}) begin
                n_fail++;
                $display("FAIL stop_resume c=%0d: got %h want %h", c, {obs, WCNT}, {exp_run(c), wexp});
            end
        end
        RUN = 1'b0;
        $display("test_stop_resume: done");
    endtask

    task automatic test_mid_reset();
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            n_checks++;
            if (obs !== exp_run(c)) begin
                n_fail++;
                $display("FAIL mid_reset_pre c=%0d: got %h want %h", c, obs, exp_run(c));
            end
        end
        rst = 1'b1; RUN = 1'b0;
        tick();
        n_checks++;
        if ({obs, WCNT} !== 14'h0) begin
            n_fail++;
            $display("FAIL mid_reset_abort: got %h want 0000", {obs, WCNT});
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({obs, WCNT} !== 14'h0) begin
                n_fail++;
                $display("FAIL mid_reset_idle cyc %0d: got %h want 0000", i, {obs, WCNT});
            end
        end
        RUN = 1'b1;
        tick();
        n_checks++;
        if ({obs, WCNT} !== {exp_run(1), 2'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_restart: got %h want %h", {obs, WCNT}, {exp_run(1), 2'd0});
        end
        RUN = 1'b0;
        $display("test_mid_reset: done");
    endtask

    task automatic test_four_words();
        int wend_n = 0;
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= 449; c++) begin
            tick();
            if (c <= 448 && WEND) wend_n++;
            n_checks++;
            if (obs !== exp_run(c)) begin
                n_fail++;
                $display("FAIL four_words c=%0d: got %h want %h", c, obs, exp_run(c));
            end
            if ((c - 1) % 112 == 0) begin
                n_checks++;
                if (WCNT !== 2'(((c - 1) / 112) % 4)) begin
                    n_fail++;
                    $display("FAIL four_words_wcnt c=%0d: got %0d want %0d", c, WCNT, ((c - 1) / 112) % 4);
                end
            end
        end
        n_checks++;
        if (wend_n !== 4) begin
            n_fail++;
            $display("FAIL four_words_wend_count: got %0d want 4", wend_n);
        end
        RUN = 1'b0;
        $display("test_four_words: done");
    endtask

    initial begin
        rst = 1'b1; RUN = 1'b0; STEP = 1'b0;
        test_reset();
        test_run_word();
        test_step();
        test_stop();
        test_stop_resume();
        test_mid_reset();
        test_four_words();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
